// File: rtl/rgb_layer_mux.sv
// Pixel output stage: fixed-priority layer compositing over a background colour,
// per-layer blinking from a frame counter, forced blanking, 2-stage registered pipeline.
module rgb_layer_mux #(
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned LAYERS       = 3,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [LAYERS-1:0]           layer_on,
  input  logic [LAYERS*COLOR_W-1:0]   layer_rgb,
  input  logic [LAYERS-1:0]           blink_mask,
  input  logic [COLOR_W-1:0]          bg_rgb,
  input  logic                        force_black,
  output logic [COLOR_W-1:0]          rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        video_on_out,
  output logic                        blink_phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_vsync_prev;
  logic               w_frame_edge;
  logic [LAYERS-1:0]  w_vis;
  logic [COLOR_W-1:0] w_sel;

  logic [COLOR_W-1:0] r_s1_rgb;
  logic               r_s1_video_on;
  logic               r_s1_force_black;
  logic               r_s1_hsync;
  logic               r_s1_vsync;

  assign w_frame_edge = r_vsync_prev & ~vsync_in;
  assign w_vis        = layer_on & (~blink_mask | {LAYERS{blink_phase}});

  // Lowest visible index wins: scan from the top so the last hit is the winner.
  always_comb begin
    w_sel = bg_rgb;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (w_vis[i]) begin
        w_sel = layer_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Frame counter and blink phase, advanced once per vsync falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_prev <= 1'b1;
      r_frame_cnt  <= '0;
      blink_phase  <= 1'b1;
    end else begin
      r_vsync_prev <= vsync_in;
      if (w_frame_edge) begin
        if (r_frame_cnt == CNT_MAX) begin
          r_frame_cnt <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stage 1: captured selection plus the controls it travels with.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_rgb         <= '0;
      r_s1_video_on    <= 1'b0;
      r_s1_force_black <= 1'b0;
      r_s1_hsync       <= 1'b1;
      r_s1_vsync       <= 1'b1;
    end else begin
      r_s1_rgb         <= w_sel;
      r_s1_video_on    <= video_on;
      r_s1_force_black <= force_black;
      r_s1_hsync       <= hsync_in;
      r_s1_vsync       <= vsync_in;
    end
  end

  // Stage 2: blanking overrides everything, including the background.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb          <= '0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      video_on_out <= 1'b0;
    end else begin
      rgb          <= (r_s1_video_on && !r_s1_force_black) ? r_s1_rgb : '0;
      hsync_out    <= r_s1_hsync;
      vsync_out    <= r_s1_vsync;
      video_on_out <= r_s1_video_on;
    end
  end

endmodule

// File: tb/tb_rgb_layer_mux.sv
// Bench for rgb_layer_mux: scenario tasks compared against a frame-count based reference model.
module tb_rgb_layer_mux;
  localparam int unsigned W  = 12;
  localparam int unsigned L  = 3;
  localparam int unsigned BF = 2;

  logic           clk = 1'b0;
  logic           reset, video_on, hsync_in, vsync_in, force_black;
  logic [L-1:0]   layer_on, blink_mask;
  logic [L*W-1:0] layer_rgb;
  logic [W-1:0]   bg_rgb;
  logic [W-1:0]   rgb;
  logic           hsync_out, vsync_out, video_on_out, blink_phase;

  int n_cmp = 0;
  int n_err = 0;

  rgb_layer_mux #(.COLOR_W(W), .LAYERS(L), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .blink_mask(blink_mask), .bg_rgb(bg_rgb),
    .force_black(force_black), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .video_on_out(video_on_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  // Reference model: phase derived from total frame edges seen; the visible pixel
  // of each cycle is computed outright and shown after a two-edge latency.
  int         m_edges;
  logic       m_prev_vs;
  logic [W-1:0] m_pix, h_rgb, exp_rgb;
  logic       m_phase, m_found;
  logic       h_hs, h_vs, h_von, exp_hs, exp_vs, exp_von, exp_phase;

  always @(posedge clk) begin
    if (reset) begin
      m_edges = 0; m_prev_vs = 1'b1;
      h_rgb = '0; h_hs = 1'b1; h_vs = 1'b1; h_von = 1'b0;
      exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_von = 1'b0; exp_phase = 1'b1;
    end else begin
      m_phase = ((m_edges / BF) % 2) == 0;
      m_pix = bg_rgb; m_found = 1'b0;
      for (int i = 0; i < L; i++) begin
        if (!m_found && layer_on[i] && (!blink_mask[i] || m_phase)) begin
          m_pix = layer_rgb[i*W +: W]; m_found = 1'b1;
        end
      end
      if (!video_on || force_black) m_pix = '0;
      exp_rgb = h_rgb; exp_hs = h_hs; exp_vs = h_vs; exp_von = h_von;
      h_rgb = m_pix; h_hs = hsync_in; h_vs = vsync_in; h_von = video_on;
      if (m_prev_vs && !vsync_in) m_edges++;
      m_prev_vs = vsync_in;
      exp_phase = ((m_edges / BF) % 2) == 0;
    end
  end

  task automatic test_reset();
    reset = 1'b1; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; force_black = 1'b0;
    layer_on = '0; blink_mask = '0; layer_rgb = '0; bg_rgb = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rgb, hsync_out, vsync_out, video_on_out, blink_phase} !== {12'h000, 4'b1101}) begin
      n_err++;
      $display("FAIL reset_state rgb=%h hs=%b vs=%b von=%b ph=%b, want 000 1 1 0 1",
               rgb, hsync_out, vsync_out, video_on_out, blink_phase);
    end
    reset = 1'b0;
  endtask

  task automatic test_background();
    logic hs_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    video_on = 1'b1; layer_on = 3'b000; bg_rgb = 12'h00F;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        n_cmp++;
        if (rgb !== 12'h00F || hsync_out !== hs_pat[j-2] || vsync_out !== 1'b1) begin
          n_err++;
          $display("FAIL background rgb=%h hs=%b vs=%b, want 00F %b 1", rgb, hsync_out, vsync_out, hs_pat[j-2]);
        end
      end
      if (j < 8) hsync_in = hs_pat[j];
    end
    hsync_in = 1'b1;
  endtask

  task automatic test_priority();
    logic [2:0]   on_pat [2] = '{3'b110, 3'b111};
    logic [W-1:0] want   [2] = '{12'h0F0, 12'hABC};
    layer_rgb = {12'hF00, 12'h0F0, 12'hABC};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); layer_on = on_pat[k];
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rgb !== want[k]) begin
        n_err++; $display("FAIL priority_%0d rgb=%h, want %h", k, rgb, want[k]);
      end
      n_cmp++;
      if (rgb !== exp_rgb || video_on_out !== exp_von) begin
        n_err++; $display("FAIL priority_model rgb=%h/%h von=%b/%b", rgb, exp_rgb, video_on_out, exp_von);
      end
    end
  endtask

  task automatic test_blanking();
    logic         vo_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] want   [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'hFFF};
    layer_rgb = {12'h111, 12'h222, 12'hFFF}; layer_on = 3'b001; force_black = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        n_cmp++;
        if (rgb !== want[j-2] || video_on_out !== vo_pat[j-2]) begin
          n_err++; $display("FAIL blank_video rgb=%h von=%b, want %h %b", rgb, video_on_out, want[j-2], vo_pat[j-2]);
        end
      end
      if (j < 4) video_on = vo_pat[j];
    end
    force_black = 1'b1; video_on = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rgb !== 12'h000 || video_on_out !== 1'b1) begin
      n_err++; $display("FAIL force_black rgb=%h von=%b, want 000 1", rgb, video_on_out);
    end
    force_black = 1'b0;
  endtask

  task automatic test_blink();
    logic [W-1:0] want;
    reset = 1'b1; vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; video_on = 1'b1; blink_mask = 3'b001; layer_on = 3'b011;
    layer_rgb = {12'h456, 12'h123, 12'hFFF};
    for (int f = 0; f < 6; f++) begin
      vsync_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (c == 6) begin
          want = ((f / 2) % 2 == 0) ? 12'hFFF : 12'h123;
          n_cmp++;
          if (rgb !== want || blink_phase !== ((f / 2) % 2 == 0)) begin
            n_err++; $display("FAIL blink_frame_%0d rgb=%h ph=%b, want %h %b", f, rgb, blink_phase, want, (f / 2) % 2 == 0);
          end
        end
        n_cmp++;
        if (rgb !== exp_rgb || blink_phase !== exp_phase || vsync_out !== exp_vs) begin
          n_err++; $display("FAIL blink_model f=%0d c=%0d rgb=%h/%h ph=%b/%b vs=%b/%b", f, c, rgb, exp_rgb, blink_phase, exp_phase, vsync_out, exp_vs);
        end
        if (c == 7) vsync_in = 1'b0;
      end
    end
    vsync_in = 1'b1;
  endtask

  task automatic test_vsync_hold();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; vsync_in = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (blink_phase !== 1'b1 || blink_phase !== exp_phase) begin
      n_err++; $display("FAIL vsync_hold_one_edge ph=%b, want 1", blink_phase);
    end
    vsync_in = 1'b1; repeat (3) @(negedge clk);
    vsync_in = 1'b0; repeat (3) @(negedge clk);
    n_cmp++;
    if (blink_phase !== 1'b0 || blink_phase !== exp_phase) begin
      n_err++; $display("FAIL vsync_hold_two_edges ph=%b, want 0", blink_phase);
    end
    vsync_in = 1'b1;
  endtask

  task automatic test_reset_midline();
    blink_mask = 3'b000; layer_on = 3'b001; layer_rgb = {12'h111, 12'h222, 12'hFFF};
    video_on = 1'b1; hsync_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rgb !== 12'h000 || hsync_out !== 1'b1 || blink_phase !== 1'b1) begin
      n_err++; $display("FAIL reset_midline rgb=%h hs=%b ph=%b, want 000 1 1", rgb, hsync_out, blink_phase);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rgb !== 12'h000) begin
      n_err++; $display("FAIL reset_release_1 rgb=%h, want 000", rgb);
    end
    @(negedge clk);
    n_cmp++;
    if (rgb !== 12'hFFF || hsync_out !== 1'b0) begin
      n_err++; $display("FAIL reset_release_2 rgb=%h hs=%b, want FFF 0", rgb, hsync_out);
    end
    hsync_in = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({rgb, hsync_out, vsync_out, video_on_out, blink_phase} !==
          {exp_rgb, exp_hs, exp_vs, exp_von, exp_phase}) begin
        n_err++;
        $display("FAIL random_%0d rgb=%h/%h hs=%b/%b vs=%b/%b von=%b/%b ph=%b/%b", n, rgb, exp_rgb,
                 hsync_out, exp_hs, vsync_out, exp_vs, video_on_out, exp_von, blink_phase, exp_phase);
      end
      reset       = ($urandom_range(0, 299) == 0);
      video_on    = ($urandom_range(0, 7) != 0);
      force_black = ($urandom_range(0, 15) == 0);
      hsync_in    = ($urandom_range(0, 9) != 0);
      vsync_in    = (n % 40) >= 3 + (n / 400) % 4;
      layer_on    = 3'($urandom);
      blink_mask  = 3'($urandom);
      layer_rgb   = 36'({$urandom(), $urandom()});
      bg_rgb      = 12'($urandom);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_background();
    test_priority();
    test_blanking();
    test_blink();
    test_vsync_hold();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rgb_layer_mux.md
Name: rgb_layer_mux

Overview:
- Parametrised pixel output stage for the VGA path.
- Composites LAYERS colour sources (text, graphics, cursor, ...) by fixed priority over a programmable background colour.
- Adds per-layer blinking from a frame counter, forced blanking, and a 2-stage registered pipeline with matching sync delay.
- Sits between the pixel generators and the VGA pins; replaces the single-source combinational RGB mux.

Parameters:
COLOR_W, 12, bits per pixel (4:4:4 RGB by default)
LAYERS, 3, number of colour layers; index 0 = highest priority
BLINK_FRAMES, 30, frames per blink half-period (must be >= 1)

Ports:
clk  in  1  pixel-domain clock
reset  in  1  synchronous, active-high reset
video_on  in  1  active display region flag from the sync generator
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
layer_on  in  LAYERS  per-layer pixel-valid flags
layer_rgb  in  LAYERS*COLOR_W  packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W]
blink_mask  in  LAYERS  1 = layer i is subject to blinking
bg_rgb  in  COLOR_W  background colour when no layer is visible
force_black  in  1  1 = blank the output regardless of video_on
rgb  out  COLOR_W  registered pixel to the DAC/pins
hsync_out  out  1  hsync_in delayed 2 cycles
vsync_out  out  1  vsync_in delayed 2 cycles
video_on_out  out  1  video_on delayed 2 cycles
blink_phase  out  1  current blink state; 1 = blinking layers visible

Behaviour:
- Reset (synchronous, active-high):
  - rgb=0, hsync_out=1, vsync_out=1, video_on_out=0, blink_phase=1.
  - Frame counter = 0, vsync edge register = 1.
  - All pipeline registers are cleared to the same inactive values.
  - Reset asserted mid-frame discards in-flight pixels. rgb stays 0 for 2 cycles after reset release before live data appears.
- Visibility of layer i: vis[i] = layer_on[i] & (~blink_mask[i] | blink_phase).
- Stage 1 (cycle n):
  - sel = layer_rgb of the lowest index i with vis[i]=1; otherwise sel = bg_rgb.
  - Registers sel, video_on, force_black, hsync_in, vsync_in.
- Stage 2 (cycle n+1):
  - rgb <= 0 if the stage-1 video_on is 0 or the stage-1 force_black is 1; otherwise rgb <= sel.
  - Syncs and video_on advance into their output registers.
- Latency: input at cycle n appears on rgb/hsync_out/vsync_out/video_on_out at cycle n+2. All four outputs stay mutually aligned.
- Blanking has priority over the background: bg_rgb is never driven outside the active region.
- Frame edge: vsync_in falling (previous 1, current 0), detected in one cycle.
  - On each frame edge: if counter == BLINK_FRAMES-1, counter <= 0 and blink_phase toggles; otherwise counter increments.
  - BLINK_FRAMES=1 toggles every frame.
  - Counter width = clog2(BLINK_FRAMES), minimum 1 bit.
- A blink_phase change is used by stage 1 from the following cycle. It is not applied retroactively to pixels already in the pipeline.
- A vsync_in held low for many cycles counts as one frame edge only.
- layer_on and blink_mask are treated as don't-care for layers outside [0, LAYERS-1]. No X must propagate when all layer_on bits are 0.
- There is no internal state other than the pipeline, counter, edge register and blink_phase. The block is purely streaming: no back-pressure, one pixel per clock.

Test Plan:
1. Reset, then video_on=1, layer_on=3'b000, bg_rgb=12'h00F -> rgb=12'h00F from the 3rd cycle after the inputs are applied. hsync_out/vsync_out follow inputs with exactly 2-cycle delay.
2. layer_on=3'b110, layer_rgb={12'hF00, 12'h0F0, 12'hABC} -> rgb=12'h0F0 (layer 1 wins). With layer_on=3'b111 -> rgb=12'hABC.
3. video_on toggled 1,0,1 on consecutive cycles with layer 0 = 12'hFFF -> rgb = FFF, 000, FFF, shifted by 2 cycles. Repeat with force_black=1 and video_on=1 -> rgb=000.
4. BLINK_FRAMES=2, blink_mask=3'b001, layer_on=3'b011, layer_rgb[0]=12'hFFF, layer_rgb[1]=12'h123:
   - frames 0-1 -> FFF, frames 2-3 -> 123, frames 4-5 -> FFF.
   - blink_phase toggles exactly on the vsync falling edges ending frames 1 and 3.
5. vsync_in held low 100 cycles, then high, then low again -> counter increments exactly twice.
6. Assert reset for 1 cycle mid-line with layer 0 active -> rgb=0, hsync_out=1, blink_phase=1 the next cycle. Live pixel reappears 2 cycles after reset deasserts.
